// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: picks one of NUM_REQ valid/ready writeback
// sources per cycle and presents a registered {wb_en, wb_sel, wb_data} packet.
module wb_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*5-1:0]       req_sel,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [37:0]                writeback_packet,
  output logic [$clog2(NUM_REQ)-1:0] wb_src,
  output logic [CNT_W-1:0]           conflict_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_sel_q, wb_sel_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [SRC_W-1:0] wb_src_q, wb_src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SRC_W-1:0] scan;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [4:0]       sel_mux;
  logic [31:0]      data_mux;
  logic             multi_req;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(NUM_REQ - 1)) ? '0 : i + SRC_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Scan starts at rr_ptr (round-robin) or index 0 (fixed priority) and wraps.
  always_comb begin
    scan      = (PRIO_MODE == 1) ? '0 : rr_ptr_q;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
    if (reset) gnt_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_mux  = '0;
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        sel_mux  = req_sel[i*5 +: 5];
        data_mux = req_data[i*32 +: 32];
      end
    end
  end

  assign multi_req = ($countones(req_valid) > 1);

  always_comb begin
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    wb_src_d  = wb_src_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = multi_req ? sat_inc(cnt_q) : cnt_q;
    if (gnt_found) begin
      // Writes to x0 still complete the handshake; only the enable is dropped.
      wb_en_d   = (sel_mux != 5'd0);
      wb_sel_d  = sel_mux;
      wb_data_d = data_mux;
      wb_src_d  = gnt_idx;
      rr_ptr_d  = wrap_inc(gnt_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
      cnt_q     <= cnt_d;
    end
  end

  assign writeback_packet = {wb_en_q, wb_sel_q, wb_data_q};
  assign wb_src           = wb_src_q;
  assign conflict_cnt     = cnt_q;

endmodule
